ysyx_23060077_lsu: RTL and testbench

//  Load/store unit between the execute stage and write-back. Accepts one memory op per

---
 rtl/ysyx_23060077_lsu.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060077_lsu.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_lsu.sv
// Load/store unit: one memory op per transaction over a word-aligned request/response port,
// returning extended load data (or a misalignment error) to write-back.
module ysyx_23060077_lsu #(
    parameter int DATA_WIDTH    = 32,
    parameter int LSU_OPT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LSU_OPT_WIDTH-1:0] lsu_opt,
    input  logic [DATA_WIDTH-1:0]    lsu_addr,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_wen,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [DATA_WIDTH/8-1:0]  mem_wmask,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    lsu_result,
    output logic                     lsu_err
);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_LB  = LSU_OPT_WIDTH'(1);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_LH  = LSU_OPT_WIDTH'(2);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_LW  = LSU_OPT_WIDTH'(3);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_LBU = LSU_OPT_WIDTH'(4);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_LHU = LSU_OPT_WIDTH'(5);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_SB  = LSU_OPT_WIDTH'(6);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_SH  = LSU_OPT_WIDTH'(7);
    localparam logic [LSU_OPT_WIDTH-1:0] OPT_SW  = LSU_OPT_WIDTH'(8);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [LSU_OPT_WIDTH-1:0]   opt_reg;
    logic [1:0]                 off_reg;
    logic                       wen_reg;
    logic [DATA_WIDTH-1:0]      addr_reg;
    logic [DATA_WIDTH-1:0]      wdata_reg;
    logic [DATA_WIDTH/8-1:0]    wmask_reg;
    logic [DATA_WIDTH-1:0]      result_reg;
    logic                       err_reg;

    logic                       is_load, is_store, misaligned;
    logic [DATA_WIDTH/8-1:0]    store_mask;
    logic [DATA_WIDTH-1:0]      rdata_shifted, load_ext;

    // Decode of the incoming op; unknown codes fall through as pass-through (NONE).
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        store_mask = '0;
        case (lsu_opt)
            OPT_LB, OPT_LBU: is_load = 1'b1;
            OPT_LH, OPT_LHU: begin
                is_load    = 1'b1;
                misaligned = lsu_addr[0];
            end
            OPT_LW: begin
                is_load    = 1'b1;
                misaligned = |lsu_addr[1:0];
            end
            OPT_SB: begin
                is_store   = 1'b1;
                store_mask = 4'b0001 << lsu_addr[1:0];
            end
            OPT_SH: begin
                is_store   = 1'b1;
                misaligned = lsu_addr[0];
                store_mask = 4'b0011 << lsu_addr[1:0];
            end
            OPT_SW: begin
                is_store   = 1'b1;
                misaligned = |lsu_addr[1:0];
                store_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata_shifted = mem_rdata >> {off_reg, 3'b000};
        case (opt_reg)
            OPT_LB:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            OPT_LBU: load_ext = {24'd0, rdata_shifted[7:0]};
            OPT_LH:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            OPT_LHU: load_ext = {16'd0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = ((is_load || is_store) && !misaligned) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_rsp_valid) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            opt_reg    <= '0;
            off_reg    <= '0;
            wen_reg    <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wmask_reg  <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                opt_reg    <= lsu_opt;
                off_reg    <= lsu_addr[1:0];
                result_reg <= '0;
                err_reg    <= (is_load || is_store) && misaligned;
                // Memory-side fields only change when a request will actually be issued.
                if ((is_load || is_store) && !misaligned) begin
                    wen_reg   <= is_store;
                    addr_reg  <= {lsu_addr[DATA_WIDTH-1:2], 2'b00};
                    wdata_reg <= is_store ? (lsu_wdata << {lsu_addr[1:0], 3'b000}) : '0;
                    wmask_reg <= store_mask;
                end
            end
            if (state_reg == WAIT && mem_rsp_valid && !wen_reg) begin
                result_reg <= load_ext;
            end
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign mem_req_valid = (state_reg == REQ);
    assign out_valid     = (state_reg == DONE);
    assign mem_wen       = wen_reg;
    assign mem_addr      = addr_reg;
    assign mem_wdata     = wdata_reg;
    assign mem_wmask     = wmask_reg;
    assign lsu_result    = result_reg;
    assign lsu_err       = err_reg;
endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Scoreboard bench for the LSU: the driver pushes expected requests/results from a
// byte-level memory model, separate monitors pop and compare on each DUT handshake.
module tb_ysyx_23060077_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  lsu_opt = '0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] lsu_result;
    logic        lsu_err;

    always #5 clk = ~clk;

    ysyx_23060077_lsu #(.DATA_WIDTH(32), .LSU_OPT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .lsu_opt(lsu_opt), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .lsu_result(lsu_result), .lsu_err(lsu_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;
    typedef struct {
        logic [31:0] result;
        logic        err;
    } res_t;

    req_t        req_q[$];
    res_t        out_q[$];
    logic [31:0] ref_mem [bit [29:0]];
    logic [31:0] bus_mem [bit [29:0]];

    int vectors = 0;
    int miscompares = 0;
    bit busy = 1'b0;
    int hold_req = 0, hold_out = 0;
    bit rsp_block = 1'b0, mem_manual = 1'b0, pend = 1'b0;
    int dly = 0;
    logic [31:0] rsp_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] init_word(input bit [29:0] wa);
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_rd(input bit [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] bus_rd(input bit [29:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        ref_mem[addr[31:2]] = word;
        bus_mem[addr[31:2]] = word;
    endtask

    // Reference model: derives the expected memory request and result from the op rules.
    task automatic model(input logic [3:0] opt, input logic [31:0] addr, input logic [31:0] wdata,
                         output bit pass);
        int unsigned off = addr % 4;
        int unsigned size;
        bit load, store, mis;
        logic [31:0] w, v, mask;
        req_t r;
        res_t o;
        load = 0; store = 0; mis = 0; size = 0;
        case (opt)
            1, 4: begin load = 1; size = 1; end
            2, 5: begin load = 1; size = 2; mis = (addr % 2) != 0; end
            3:    begin load = 1; size = 4; mis = off != 0; end
            6:    begin store = 1; size = 1; end
            7:    begin store = 1; size = 2; mis = (addr % 2) != 0; end
            8:    begin store = 1; size = 4; mis = off != 0; end
            default: ;
        endcase
        o.result = 0;
        o.err = (load || store) && mis;
        pass = !(load || store) || mis;
        if (!pass) begin
            r.addr = addr - off;
            r.wen = store;
            r.wdata = store ? (wdata << (8 * off)) : 32'd0;
            mask = ((32'd1 << size) - 1) << off;
            r.wmask = store ? mask[3:0] : 4'd0;
            w = ref_rd(addr[31:2]);
            if (store) begin
                for (int i = 0; i < 4; i++)
                    if (mask[i]) w[8*i +: 8] = r.wdata[8*i +: 8];
                ref_mem[addr[31:2]] = w;
            end else begin
                v = w >> (8 * off);
                case (opt)
                    1: begin v = v & 32'hFF;   o.result = (v >= 128)   ? v - 32'd256   : v; end
                    4: o.result = v & 32'hFF;
                    2: begin v = v & 32'hFFFF; o.result = (v >= 32768) ? v - 32'd65536 : v; end
                    5: o.result = v & 32'hFFFF;
                    default: o.result = w;
                endcase
            end
            req_q.push_back(r);
        end
        out_q.push_back(o);
    endtask

    task automatic issue(input logic [3:0] opt, input logic [31:0] addr, input logic [31:0] wdata);
        bit ok, pass;
        @(posedge clk); #1;
        in_valid = 1'b1; lsu_opt = opt; lsu_addr = addr; lsu_wdata = wdata;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            fail("in_ready_timeout");
            in_valid = 1'b0;
            return;
        end
        model(opt, addr, wdata, pass);
        $display("txn opt=%0d addr=%h wdata=%h pass=%0b", opt, addr, wdata, pass);
        @(posedge clk); #1;
        busy = 1'b1;
        in_valid = 1'b0;
        lsu_opt = 4'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
        if (pass) begin
            @(negedge clk);
            check("pass_latency_out_valid", {31'd0, out_valid}, 32'd1);
            check("pass_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!busy && out_q.size() == 0 && req_q.size() == 0) return;
        end
        fail("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_lsu_result"}, lsu_result, 32'd0);
        check({tag, "_lsu_err"}, {31'd0, lsu_err}, 32'd0);
    endtask

    // in_ready must track whether a transaction is in flight.
    initial forever begin
        @(negedge clk);
        if (rst_n) check("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
    end

    // Memory monitor/responder.
    initial begin
        bit   req_hs, have;
        req_t held, e;
        have = 0;
        forever begin
            @(negedge clk);
            req_hs = 0;
            if (rst_n && mem_req_valid) begin
                if (have) begin
                    check("req_stable_addr", mem_addr, held.addr);
                    check("req_stable_wen", {31'd0, mem_wen}, {31'd0, held.wen});
                    check("req_stable_wdata", mem_wdata, held.wdata);
                    check("req_stable_wmask", {28'd0, mem_wmask}, {28'd0, held.wmask});
                end
                if (mem_req_ready) begin
                    req_hs = 1;
                    have = 0;
                    if (req_q.size() == 0) fail("unexpected_mem_req");
                    else begin
                        e = req_q.pop_front();
                        check("req_addr", mem_addr, e.addr);
                        check("req_wen", {31'd0, mem_wen}, {31'd0, e.wen});
                        check("req_wmask", {28'd0, mem_wmask}, {28'd0, e.wmask});
                        if (e.wen) check("req_wdata", mem_wdata, e.wdata);
                    end
                    rsp_word = bus_rd(mem_addr[31:2]);
                    if (mem_wen) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_wmask[i]) rsp_word[8*i +: 8] = mem_wdata[8*i +: 8];
                        bus_mem[mem_addr[31:2]] = rsp_word;
                    end
                end else begin
                    have = 1;
                    held.addr = mem_addr; held.wen = mem_wen;
                    held.wdata = mem_wdata; held.wmask = mem_wmask;
                    if (hold_req > 0) hold_req--;
                end
            end else have = 0;
            @(posedge clk); #1;
            if (!mem_manual) begin
                mem_rsp_valid = 1'b0;
                mem_rdata = $urandom;
                if (req_hs) begin pend = 1; dly = $urandom_range(0, 2); end
                else if (pend && dly > 0) dly--;
                if (pend && dly == 0 && !rsp_block) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = rsp_word;
                    pend = 0;
                end
            end
            mem_req_ready = (hold_req > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Result monitor.
    initial begin
        bit   hs, have;
        res_t held, e;
        have = 0;
        forever begin
            @(negedge clk);
            hs = 0;
            if (rst_n && out_valid) begin
                if (have) begin
                    check("out_stable_result", lsu_result, held.result);
                    check("out_stable_err", {31'd0, lsu_err}, {31'd0, held.err});
                end
                if (out_ready) begin
                    hs = 1;
                    have = 0;
                    if (out_q.size() == 0) fail("unexpected_out_valid");
                    else begin
                        e = out_q.pop_front();
                        check("lsu_result", lsu_result, e.result);
                        check("lsu_err", {31'd0, lsu_err}, {31'd0, e.err});
                    end
                end else begin
                    have = 1;
                    held.result = lsu_result; held.err = lsu_err;
                    if (hold_out > 0) hold_out--;
                end
            end else have = 0;
            @(posedge clk); #1;
            if (hs) busy = 1'b0;
            out_ready = (hold_out > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Spec examples.
        preload(32'h8000_0000, 32'h80FF_0000);
        issue(4'd1, 32'h8000_0003, 32'h0);
        wait_idle();
        preload(32'h8000_0000, 32'hBEEF_1234);
        issue(4'd5, 32'h8000_0002, 32'h0);
        wait_idle();
        issue(4'd6, 32'h8000_0001, 32'h0000_00AB);
        issue(4'd3, 32'h8000_0002, 32'h0);
        wait_idle();

        // Long stalls on both handshakes.
        hold_req = 5; hold_out = 3;
        issue(4'd3, 32'h8000_0004, 32'h0);
        wait_idle();
        hold_req = 5; hold_out = 3;
        issue(4'd7, 32'h8000_0006, 32'h1234_5678);
        wait_idle();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] opt;
            opt = (n % 5 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
            issue(opt, 32'h8000_0000 + $urandom_range(0, 63), $urandom);
        end
        wait_idle();

        // Reset while waiting for a response.
        rsp_block = 1'b1;
        issue(4'd3, 32'h8000_0010, 32'h0);
        for (int c = 0; c < 200 && req_q.size() != 0; c++) @(negedge clk);
        if (req_q.size() != 0) fail("wait_state_timeout");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        out_q.delete();
        busy = 1'b0;
        pend = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mem_manual = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_manual = 1'b0;
        rsp_block = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("late_rsp_out_valid", {31'd0, out_valid}, 32'd0);
            check("late_rsp_in_ready", {31'd0, in_ready}, 32'd1);
        end
        issue(4'd9, 32'h8000_0020, 32'h0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
